// File: rtl/gray_pkg.sv
// Shared definitions for the grayscale 3x3 window generator and the
// downstream spatial filters that consume its window bus.
package gray_pkg;

    // Default pixel width, matching the grayscale converter output
    localparam int GRAY_INT_WIDTH = 8;

    // Window element index: P<r><c> = r*3 + c
    // r=0 is the oldest (top) row, c=0 the oldest (left) column
    localparam int P00 = 0;
    localparam int P01 = 1;
    localparam int P02 = 2;
    localparam int P10 = 3;
    localparam int P11 = 4;
    localparam int P12 = 5;
    localparam int P20 = 6;
    localparam int P21 = 7;
    localparam int P22 = 8;

    // Width of the packed window bus at the default pixel width
    localparam int WIN_W = 9 * GRAY_INT_WIDTH;

    typedef logic [GRAY_INT_WIDTH-1:0] gray_pix_t;

    // LSB position of window element (r,c) for a given pixel width
    function automatic int win_lsb(input int r, input int c, input int w);
        return (r * 3 + c) * w;
    endfunction

endpackage

// File: rtl/gray_line_buffer.sv
// One raster line of pixel storage. Single port, read-before-write:
// the read is combinational on the address, the write lands on the clock
// edge, so a read and write of the same column in one cycle returns the
// previous line's pixel. Contents are deliberately not reset.
module gray_line_buffer #(
    parameter int INT_WIDTH = 8,
    parameter int DEPTH     = 640
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [INT_WIDTH-1:0]     i_wdata,
    output logic [INT_WIDTH-1:0]     o_rdata
);

    logic [INT_WIDTH-1:0] r_mem [DEPTH];

    // Registered write of the accepted pixel
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/gray_window_3x3.sv
// Sliding 3x3 neighbourhood builder for a raster-order grayscale stream.
// Two line buffers supply the two previous rows; a 3x3 shift register
// holds the last three columns. One window is emitted (registered, one
// clock after the accept edge) per interior centre pixel.
//
// Optional feature: define GRAY_WIN_FRAME_DONE_EN to add the frame_done
// output, a one-cycle pulse alongside the window of the frame's last pixel.
module gray_window_3x3
    import gray_pkg::*;
#(
    parameter int INT_WIDTH  = GRAY_INT_WIDTH,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [INT_WIDTH-1:0]   grayscale,
    input  logic                   din_valid,
    output logic [9*INT_WIDTH-1:0] win,
    output logic                   dout_valid
`ifdef GRAY_WIN_FRAME_DONE_EN
    ,
    output logic                   frame_done
`endif
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(2);
    localparam logic [RW-1:0] ROW_MIN  = RW'(2);

    logic [CW-1:0]            r_col;
    logic [RW-1:0]            r_row;
    logic [9*INT_WIDTH-1:0]   r_sh;
    logic [9*INT_WIDTH-1:0]   r_win;
    logic                     r_dout_valid;

    logic                     w_accept;
    logic                     w_col_last;
    logic                     w_row_last;
    logic                     w_emit;
    logic [INT_WIDTH-1:0]     w_lb0_rd;
    logic [INT_WIDTH-1:0]     w_lb1_rd;
    logic [9*INT_WIDTH-1:0]   w_sh_next;

    // A pixel presented while reset is asserted is never taken, so it must
    // not disturb the line buffers either.
    assign w_accept   = din_valid & rst_n;
    assign w_col_last = (r_col == COL_LAST);
    assign w_row_last = (r_row == ROW_LAST);
    // Rows/columns 0..1 never complete a neighbourhood; this also hides
    // mixed-line windows after a wrap and stale rows after a frame wrap.
    assign w_emit     = w_accept && (r_row >= ROW_MIN) && (r_col >= COL_MIN);

    // lb0 holds row-1, lb1 holds row-2; lb1 is refilled from lb0's old value
    gray_line_buffer #(
        .INT_WIDTH (INT_WIDTH),
        .DEPTH     (IMG_WIDTH)
    ) u_lb0 (
        .clk     (clk),
        .i_we    (w_accept),
        .i_addr  (r_col),
        .i_wdata (grayscale),
        .o_rdata (w_lb0_rd)
    );

    gray_line_buffer #(
        .INT_WIDTH (INT_WIDTH),
        .DEPTH     (IMG_WIDTH)
    ) u_lb1 (
        .clk     (clk),
        .i_we    (w_accept),
        .i_addr  (r_col),
        .i_wdata (w_lb0_rd),
        .o_rdata (w_lb1_rd)
    );

    // Raster position of the next pixel to be accepted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // Next shift-register contents: columns move left, new column enters at c=2
    always_comb begin
        w_sh_next = r_sh;
        for (int r = 0; r < 3; r++) begin
            w_sh_next[win_lsb(r, 0, INT_WIDTH) +: INT_WIDTH] =
                r_sh[win_lsb(r, 1, INT_WIDTH) +: INT_WIDTH];
            w_sh_next[win_lsb(r, 1, INT_WIDTH) +: INT_WIDTH] =
                r_sh[win_lsb(r, 2, INT_WIDTH) +: INT_WIDTH];
        end
        w_sh_next[P02*INT_WIDTH +: INT_WIDTH] = w_lb1_rd;
        w_sh_next[P12*INT_WIDTH +: INT_WIDTH] = w_lb0_rd;
        w_sh_next[P22*INT_WIDTH +: INT_WIDTH] = grayscale;
    end

    // 3x3 shift register advances only on accepted pixels; not cleared on wrap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sh <= '0;
        end else if (w_accept) begin
            r_sh <= w_sh_next;
        end
    end

    // Output window captured only on emit so it holds between pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_win        <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_dout_valid <= w_emit;
            if (w_emit) begin
                r_win <= w_sh_next;
            end
        end
    end

    assign win        = r_win;
    assign dout_valid = r_dout_valid;

`ifdef GRAY_WIN_FRAME_DONE_EN
    logic r_frame_done;

    // Pulse with the window produced by the frame's bottom-right pixel
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_emit && w_col_last && w_row_last;
        end
    end

    assign frame_done = r_frame_done;
`endif

endmodule

// File: tb/tb_gray_window_3x3.sv
// Scoreboard bench for gray_window_3x3 on a 5x4 image, pixel = row*16+col.
`timescale 1ns/1ps
module tb_gray_window_3x3;
    import gray_pkg::*;

    localparam int W  = 8;
    localparam int IW = 5;
    localparam int IH = 4;

    logic           clk       = 1'b0;
    logic           rst_n     = 1'b0;
    logic [W-1:0]   grayscale = '0;
    logic           din_valid = 1'b0;
    logic [9*W-1:0] win;
    logic           dout_valid;
`ifdef GRAY_WIN_FRAME_DONE_EN
    logic           frame_done;
`endif

    typedef struct {
        logic [9*W-1:0] win;
        logic           fd;
    } exp_t;

    exp_t           q[$];
    int             n_tests  = 0;
    int             n_fail   = 0;
    logic [9*W-1:0] last_win = '0;

    always #5 clk = ~clk;

    gray_window_3x3 #(
        .INT_WIDTH  (W),
        .IMG_WIDTH  (IW),
        .IMG_HEIGHT (IH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .grayscale  (grayscale),
        .din_valid  (din_valid),
        .win        (win),
        .dout_valid (dout_valid)
`ifdef GRAY_WIN_FRAME_DONE_EN
        ,
        .frame_done (frame_done)
`endif
    );

    task automatic check(input string name, input logic [9*W-1:0] act, input logic [9*W-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Drive one cycle; expectation is queued right after the accept edge
    task automatic send(input logic v, input logic [W-1:0] px, input logic emit,
                        input logic [9*W-1:0] ew, input logic fd);
        exp_t e;
        din_valid = v;
        grayscale = px;
        @(posedge clk);
        if (emit) begin
            e.win = ew;
            e.fd  = fd;
            q.push_back(e);
        end
        #1;
    endtask

    // gap_mode 0: continuous; 1: one idle per pixel on rows 0-1, random 0-3 after
    task automatic send_frame(input logic [W-1:0] off, input int gap_mode);
        logic [9*W-1:0] ew;
        int             g;
        for (int r = 0; r < IH; r++) begin
            for (int c = 0; c < IW; c++) begin
                ew = '0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        ew[(i*3+j)*W +: W] = W'((r - 2 + i) * 16 + (c - 2 + j)) + off;
                send(1'b1, W'(r * 16 + c) + off, (r >= 2 && c >= 2), ew,
                     (r == IH - 1 && c == IW - 1));
                if (gap_mode == 1) begin
                    g = (r < 2) ? 1 : int'($urandom_range(0, 3));
                    for (int k = 0; k < g; k++)
                        send(1'b0, W'($urandom), 1'b0, '0, 1'b0);
                end
            end
        end
    endtask

    // One reset clock (optionally with din_valid high), then check reset outputs
    task automatic do_reset(input logic v, input logic [W-1:0] px);
        rst_n     = 1'b0;
        din_valid = v;
        grayscale = px;
        @(posedge clk);
        last_win = '0;
        #1;
        rst_n     = 1'b1;
        din_valid = 1'b0;
        @(negedge clk);
        check("rst_win", win, '0);
        check("rst_dout_valid", {71'b0, dout_valid}, '0);
`ifdef GRAY_WIN_FRAME_DONE_EN
        check("rst_frame_done", {71'b0, frame_done}, '0);
`endif
    endtask

    // Monitor: every DUT output cycle is matched against the scoreboard head
    always @(negedge clk) begin
        exp_t e;
        if (dout_valid === 1'b1) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_dout_valid: got 1 expected 0, win=%h (t=%0t)", win, $time);
            end else begin
                e = q.pop_front();
                check("win", win, e.win);
                last_win = e.win;
`ifdef GRAY_WIN_FRAME_DONE_EN
                check("frame_done", {71'b0, frame_done}, {71'b0, e.fd});
`endif
            end
        end else begin
            if (q.size() != 0) begin
                n_tests++;
                n_fail++;
                e = q.pop_front();
                $display("FAIL missing_dout_valid: got %b expected 1 for win %h (t=%0t)",
                         dout_valid, e.win, $time);
            end
            check("win_hold", win, last_win);
`ifdef GRAY_WIN_FRAME_DONE_EN
            check("frame_done_idle", {71'b0, frame_done}, '0);
`endif
        end
    end

    initial begin
        // reset state
        do_reset(1'b0, '0);

        // 1: continuous frame
        send_frame(8'h00, 0);
        repeat (2) send(1'b0, 8'h5A, 1'b0, '0, 1'b0);

        // 2: same frame with idle gaps
        send_frame(8'h00, 1);
        repeat (2) send(1'b0, 8'hA5, 1'b0, '0, 1'b0);

        // 3: two back-to-back frames, second offset by 0x80
        send_frame(8'h00, 0);
        send_frame(8'h80, 0);

        // 4: reset after 7 accepted pixels, then a full frame
        for (int k = 0; k < 7; k++)
            send(1'b1, W'((k / IW) * 16 + (k % IW)) + 8'h40, 1'b0, '0, 1'b0);
        do_reset(1'b0, '0);
        send_frame(8'h00, 0);

        // 5: reset coincident with a valid pixel; that pixel must be dropped
        do_reset(1'b1, 8'hEE);
        send_frame(8'h00, 1);

        repeat (3) send(1'b0, 8'h00, 1'b0, '0, 1'b0);
        check("queue_drained", 72'(q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
